fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Instruction fetch stage feeding the IF/ID pipeline register. It generates sequential fetch addresses and issues them to instruction memory over a valid/ready request channel with in-order responses. Returned instructions are buffered, tagged with their PC, in a small FIFO. On branch, jump, mret or trap the stage is redirected, the FIFO is flushed and stale in-flight responses are discarded.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 4, FIFO entries; power of two, >= 2; also the cap on (occupancy + outstanding requests)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  fetch address, word aligned
imem_rsp_valid  in  1  instruction returned; in order; at least 1 cycle after acceptance
imem_rsp_data  in  32  returned instruction
redirect_valid  in  1  control-flow change from EX/CSR
redirect_pc  in  32  new fetch target; bits [1:0] ignored and treated as 0
id_ready  in  1  IF/ID register can accept; low means stall
id_valid  out  1  FIFO head valid
id_instr  out  32  head instruction
id_pc  out  32  PC of head instruction
fq_count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (synchronous, active-high; also applies mid-operation):
  - fetch_pc = RESET_PC, rsp_pc = RESET_PC.
  - FIFO empty; outstanding = 0; discard = 0.
  - id_valid = 0, id_instr = 32'h0000_0013 (NOP), id_pc = 0, fq_count = 0, imem_req_valid = 0.
  - A response arriving while outstanding == 0 is ignored.
- Request issue:
  - imem_req_valid = !redirect_valid && (fq_count + outstanding < DEPTH).
  - imem_req_addr = fetch_pc.
  - A request is accepted when imem_req_valid && imem_req_ready. Acceptance does fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0) and outstanding += 1.
- Response handling:
  - Every imem_rsp_valid with outstanding > 0 decrements outstanding.
  - If discard > 0: the data is dropped and discard decrements.
  - Otherwise push {rsp_pc, imem_rsp_data} into the FIFO and rsp_pc += 4.
  - The credit rule guarantees a push never overflows, including a push while full with a same-cycle pop.
- Output:
  - id_valid = !empty; id_instr and id_pc come from the head entry.
  - Pop when id_valid && id_ready. A simultaneous push and pop keeps the count unchanged.
  - While id_ready = 0, head outputs are held stable.
  - When empty, id_instr = NOP and id_pc holds its last value.
- Latency: request accepted in cycle N, response in N+1, id_valid in N+2. Sustains 1 instruction per cycle when memory is single-cycle and id_ready stays high.
- Redirect (cycle R, redirect_valid = 1):
  - No request is issued in cycle R.
  - At the R edge: FIFO flushed (a same-cycle pop or push is void); fetch_pc and rsp_pc load redirect_pc & ~3.
  - discard loads (outstanding − response-in-R). Any response in R is itself dropped.
  - From R+1: id_valid = 0 and the first request is to redirect_pc.
- Consecutive redirects: the last one wins; discard is recomputed each time.
- Redirect while discard > 0 from a prior redirect: discard is again set to the total of remaining outstanding responses.
- Reset has priority over redirect, and redirect over push/pop.

Test Plan:
- Reset, then ready=1 and 1-cycle memory returning addr+0x100 -> first request addr 0x0; id_valid in cycle 3; id_pc sequence 0x0, 0x4, 0x8; instr 0x100, 0x104.
- Hold id_ready=0 with DEPTH=4 -> fq_count saturates at 4; imem_req_valid drops once count + outstanding = 4; head (pc 0x0) stays stable. Release -> drains in order with no loss.
- 2 requests in flight, redirect_pc=0x200 -> both responses discarded; next id_pc = 0x200; fq_count = 0 in cycle R+1.
- Redirect in the same cycle as a response and a pop -> response dropped, FIFO empty; redirect_pc=0x203 fetches 0x200.
- Fetch_pc at 0xFFFF_FFFC -> next request addr 0x0000_0000; id_pc values wrap correctly.
- rst asserted with 2 outstanding -> all outputs at reset values next cycle; late responses ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-stage bundle: instruction-memory request/response channel,
// redirect input from EX/CSR, and the IF/ID-facing head of the fetch FIFO.
// The master side belongs to the fetch stage; the slave side belongs to
// memory / downstream.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [31:0]   imem_req_addr;
  logic          imem_rsp_valid;
  logic [31:0]   imem_rsp_data;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          id_ready;
  logic          id_valid;
  logic [31:0]   id_instr;
  logic [31:0]   id_pc;
  logic [CW-1:0] fq_count;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    input  id_ready,
    output id_valid, id_instr, id_pc, fq_count
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    output id_ready,
    input  id_valid, id_instr, id_pc, fq_count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage. Issues sequential word-aligned fetches under a
// credit limit (FIFO occupancy + outstanding requests <= DEPTH), buffers
// in-order responses tagged with their PC, and on redirect flushes the FIFO
// and drops every response still in flight from before the redirect.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input logic        clk,
  input logic        rst,
  fetch_queue_if.master fq
);
  localparam int            AW      = $clog2(DEPTH);
  localparam int            CW      = AW + 1;
  localparam logic [CW:0]   CREDITS = (CW+1)'(DEPTH);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, outstanding, discard;
  logic [31:0]   fetch_pc, rsp_pc, pc_hold;

  logic          empty, redirect;
  logic          req_valid, req_fire, rsp_fire, push, pop;
  logic [CW:0]   credit_used;

  // Handshake qualification; redirect voids any same-cycle push or pop.
  always_comb begin
    empty       = (count == '0);
    redirect    = fq.redirect_valid;
    credit_used = {1'b0, count} + {1'b0, outstanding};
    req_valid   = !rst && !redirect && (credit_used < CREDITS);
    req_fire    = req_valid && fq.imem_req_ready;
    rsp_fire    = fq.imem_rsp_valid && (outstanding != '0);
    push        = rsp_fire && (discard == '0) && !redirect;
    pop         = !empty && fq.id_ready && !redirect;
  end

  assign fq.imem_req_valid = req_valid;
  assign fq.imem_req_addr  = fetch_pc;
  assign fq.id_valid       = !empty;
  assign fq.id_instr       = empty ? NOP     : mem_instr[rd_ptr];
  assign fq.id_pc          = empty ? pc_hold : mem_pc[rd_ptr];
  assign fq.fq_count       = count;

  // FIFO storage; a push into the slot being popped is safe because the
  // head is read combinationally before the edge.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_pc[wr_ptr]    <= rsp_pc;
      mem_instr[wr_ptr] <= fq.imem_rsp_data;
    end
  end

  // Pointers, occupancy, request/discard credits and fetch/response PCs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
    end else if (redirect) begin
      // Everything still in flight after this edge predates the redirect.
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= outstanding - CW'(rsp_fire);
      discard     <= outstanding - CW'(rsp_fire);
      fetch_pc    <= {fq.redirect_pc[31:2], 2'b00};
      rsp_pc      <= {fq.redirect_pc[31:2], 2'b00};
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count       <= count + CW'(push) - CW'(pop);
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (push)     rsp_pc   <= rsp_pc + 32'd4;
      if (rsp_fire && (discard != '0)) discard <= discard - CW'(1);
    end
  end

  // Remember the last presented PC so id_pc stays put while empty.
  always_ff @(posedge clk) begin
    if (rst)
      pc_hold <= 32'h0;
    else if (!empty)
      pc_hold <= mem_pc[rd_ptr];
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios followed by randomized traffic,
// every cycle compared against a queue-based reference of the fetch stage.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } mreq_t;

  logic clk;
  logic rst;

  fetch_queue_if #(.DEPTH(DEPTH)) fqif ();

  fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .fq  (fqif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference state
  ent_t        q[$];
  mreq_t       mem_q[$];
  int          outst = 0;
  int          disc  = 0;
  logic [31:0] m_fpc = RESET_PC;
  logic [31:0] m_rpc = RESET_PC;
  logic [31:0] last_pc = 32'h0;
  int          cyc_n = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at negedge, check outputs, advance the reference.
  task automatic cycle(input bit r, input bit idr, input bit rqr, input bit rd,
                       input logic [31:0] rpc_in, input bit rsp_en);
    bit          rv, m_req, rsp_acc;
    logic [31:0] data, fpc_old;
    @(negedge clk);
    rv   = rsp_en && (mem_q.size() > 0) && (mem_q[0].cyc < cyc_n);
    data = rv ? mem_q[0].addr + 32'h100 : $urandom;
    rst                 = r;
    fqif.id_ready       = idr;
    fqif.imem_req_ready = rqr;
    fqif.redirect_valid = rd;
    fqif.redirect_pc    = rpc_in;
    fqif.imem_rsp_valid = rv;
    fqif.imem_rsp_data  = data;
    #1;
    m_req = !r && !rd && (q.size() + outst < DEPTH);
    chk("req_valid", 32'(fqif.imem_req_valid), 32'(m_req));
    chk("req_addr",  fqif.imem_req_addr, m_fpc);
    chk("id_valid",  32'(fqif.id_valid), 32'(q.size() > 0));
    chk("id_instr",  fqif.id_instr, (q.size() > 0) ? q[0].instr : NOP);
    chk("id_pc",     fqif.id_pc,    (q.size() > 0) ? q[0].pc : last_pc);
    chk("fq_count",  32'(fqif.fq_count), 32'(q.size()));

    fpc_old = m_fpc;
    if (r) begin
      q.delete();
      outst = 0; disc = 0;
      m_fpc = RESET_PC; m_rpc = RESET_PC;
      last_pc = 32'h0;
    end else begin
      rsp_acc = rv && (outst > 0);
      if (q.size() > 0) last_pc = q[0].pc;
      if (rd) begin
        q.delete();
        m_fpc = {rpc_in[31:2], 2'b00};
        m_rpc = {rpc_in[31:2], 2'b00};
        outst = outst - int'(rsp_acc);
        disc  = outst;
      end else begin
        if ((q.size() > 0) && idr) void'(q.pop_front());
        if (rsp_acc) begin
          if (disc > 0) disc--;
          else begin
            q.push_back('{m_rpc, data});
            m_rpc = m_rpc + 32'd4;
          end
        end
        if (m_req && rqr) begin
          m_fpc = m_fpc + 32'd4;
          outst++;
        end
        outst = outst - int'(rsp_acc);
      end
    end
    if (m_req && rqr) mem_q.push_back('{fpc_old, cyc_n});
    if (rv) void'(mem_q.pop_front());
    cyc_n++;
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    fqif.id_ready = 1'b0;
    fqif.imem_req_ready = 1'b0;
    fqif.redirect_valid = 1'b0;
    fqif.redirect_pc = 32'h0;
    fqif.imem_rsp_valid = 1'b0;
    fqif.imem_rsp_data = 32'h0;

    // reset
    repeat (2) cycle(1, 1, 1, 0, 0, 0);

    // streaming with single-cycle memory
    repeat (12) cycle(0, 1, 1, 0, 0, 1);

    // stall: FIFO fills to DEPTH, requests stop, head holds
    repeat (10) cycle(0, 0, 1, 0, 0, 1);
    #1;
    chk("stall_full",  32'(fqif.fq_count), 32'd4);
    chk("stall_noreq", 32'(fqif.imem_req_valid), 32'd0);
    repeat (10) cycle(0, 1, 1, 0, 0, 1);

    // two in flight, then redirect to 0x200
    repeat (6) cycle(0, 1, 0, 0, 0, 1);
    repeat (2) cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 1, 1, 1, 32'h200, 0);
    #1;
    chk("redir_count", 32'(fqif.fq_count), 32'd0);
    chk("redir_valid", 32'(fqif.id_valid), 32'd0);
    chk("redir_addr",  fqif.imem_req_addr, 32'h200);
    repeat (10) cycle(0, 1, 1, 0, 0, 1);

    // redirect coinciding with response and pop; low bits ignored
    cycle(0, 1, 1, 1, 32'h203, 1);
    #1;
    chk("redir2_addr",  fqif.imem_req_addr, 32'h200);
    chk("redir2_count", 32'(fqif.fq_count), 32'd0);
    repeat (8) cycle(0, 1, 1, 0, 0, 1);

    // address wrap
    cycle(0, 1, 1, 1, 32'hFFFF_FFF8, 1);
    repeat (10) cycle(0, 1, 1, 0, 0, 1);

    // reset with requests outstanding; stale responses must be ignored
    repeat (2) cycle(0, 1, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0);
    #1;
    chk("rst_count", 32'(fqif.fq_count), 32'd0);
    chk("rst_instr", fqif.id_instr, NOP);
    for (int i = 0; i < 8 && mem_q.size() > 0; i++) cycle(0, 1, 0, 0, 0, 1);
    chk("rst_stale_count", 32'(fqif.fq_count), 32'd0);
    repeat (8) cycle(0, 1, 1, 0, 0, 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit r, rd;
      r  = ($urandom_range(0, 149) == 0);
      rd = ($urandom_range(0, 19) == 0);
      cycle(r, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rd,
            $urandom, $urandom_range(0, 2) != 0);
      if (r) mem_q.delete();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
